// File: rtl/jtframe_pll_seq.sv
// rtl/jtframe_pll_seq.sv - PLL reset and lock sequencer, holds system reset until lock is stable
// Lock watchdog, retries and fail are enabled by defining JTFRAME_PLL_WDOG_EN.
module jtframe_pll_seq #(
  parameter int RST_CYC     = 16,
  parameter int STABLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 65536,
  parameter int MAXRETRY    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ok,
  output logic       fail,
  output logic [3:0] retries,
  output logic [3:0] lock_lost
);

`ifdef JTFRAME_PLL_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam int MAX_RS  = (RST_CYC > STABLE_CYC) ? RST_CYC : STABLE_CYC;
  localparam int MAX_CYC = (MAX_RS > TIMEOUT_CYC) ? MAX_RS : TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] STB_LAST   = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    RETRY_LAST = 4'(MAXRETRY - 1);

  typedef enum logic [2:0] {
    S_PRST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync;
  logic          lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], pll_locked};
  end

  assign lock_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PRST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      pll_ok    <= 1'b0;
      fail      <= 1'b0;
      retries   <= 4'd0;
      lock_lost <= 4'd0;
    end else begin
      case (state)
        S_PRST: begin
          if (cnt == RST_LAST) begin
            state   <= S_WAIT;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // lock is checked before the timeout so a simultaneous lock wins
        S_WAIT: begin
          if (lock_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (WDOG_EN) begin
            if (cnt == TMO_LAST) begin
              cnt     <= '0;
              retries <= retries + 4'd1;
              pll_rst <= 1'b1;
              if (retries == RETRY_LAST) begin
                state <= S_FAIL;
                fail  <= 1'b1;
              end else begin
                state <= S_PRST;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state   <= S_RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            pll_ok  <= 1'b1;
            retries <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state   <= S_PRST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            pll_ok  <= 1'b0;
            if (lock_lost != 4'hF) lock_lost <= lock_lost + 4'd1;
          end
        end
        S_FAIL: begin
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          pll_ok  <= 1'b0;
          fail    <= 1'b1;
        end
        default: begin
          state   <= S_PRST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          pll_ok  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_pll_seq.sv
// tb/tb_jtframe_pll_seq.sv - directed bench for jtframe_pll_seq
// Watchdog steps are built only when JTFRAME_PLL_WDOG_EN is defined.
module tb_jtframe_pll_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       pll_ok;
  logic       fail;
  logic [3:0] retries;
  logic [3:0] lock_lost;

  int checks = 0;
  int errors = 0;
  int n;

`ifdef JTFRAME_PLL_WDOG_EN
  localparam int RETRY_IN_WAIT = 1;
`else
  localparam int RETRY_IN_WAIT = 0;
`endif

  jtframe_pll_seq #(
    .RST_CYC    (16),
    .STABLE_CYC (32),
    .TIMEOUT_CYC(64),
    .MAXRETRY   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .pll_ok    (pll_ok),
    .fail      (fail),
    .retries   (retries),
    .lock_lost (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return sys_rst;
      default: return fail;
    endcase
  endfunction

  // counts edges until the selected output reaches val, giving up at limit
  task automatic wait_sig(input int which, input logic val, input int limit, output int cnt);
    cnt = 0;
    while (sig(which) !== val && cnt < limit) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #23;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_pll_ok", pll_ok, 0);
    check("rst_fail", fail, 0);
    check("rst_retries", retries, 0);
    check("rst_lock_lost", lock_lost, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 100, n);
    check("pwrup_pll_rst_width", n, 16);

    tick(100);
    pll_locked = 1'b1;
    check("pwrup_retries_in_wait", retries, RETRY_IN_WAIT);
    wait_sig(1, 1'b0, 200, n);
    check("pwrup_sys_rst_edges", n, 35);
    check("pwrup_pll_ok", pll_ok, 1);
    check("pwrup_pll_rst_low", pll_rst, 0);
    check("pwrup_retries_run", retries, 0);

    pll_locked = 1'b0;
    wait_sig(1, 1'b1, 50, n);
    check("loss_sys_rst_edges", n, 3);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_pll_ok", pll_ok, 0);
    check("loss_lock_lost", lock_lost, 1);
    wait_sig(0, 1'b0, 100, n);
    check("loss_pll_rst_width", n, 16);

    pll_locked = 1'b1;
    tick(23);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_sig(1, 1'b0, 200, n);
    check("glitch_sys_rst_edges", n + 24, 59);
    check("glitch_pll_ok", pll_ok, 1);

    for (int i = 0; i < 20; i++) begin
      pll_locked = 1'b0;
      wait_sig(1, 1'b1, 50, n);
      check("rep_loss_edges", n, 3);
      wait_sig(0, 1'b0, 100, n);
      pll_locked = 1'b1;
      wait_sig(1, 1'b0, 200, n);
      check("rep_relock_edges", n, 35);
    end
    check("lock_lost_saturated", lock_lost, 15);

    rst_n = 1'b0;
    #1;
    check("rst_clears_lock_lost", lock_lost, 0);
    check("rst_sys_rst_run", sys_rst, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 100, n);
    check("rerun_pll_rst_width", n, 16);
    tick(10);
    check("mid_stable_sys_rst", sys_rst, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pll_rst", pll_rst, 1);
    check("async_sys_rst", sys_rst, 1);
    check("async_pll_ok", pll_ok, 0);
    check("async_lock_lost", lock_lost, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 100, n);
    check("restart_pll_rst_width", n, 16);
    wait_sig(1, 1'b0, 200, n);
    check("restart_sys_rst_edges", n, 33);
    check("restart_pll_ok", pll_ok, 1);

`ifdef JTFRAME_PLL_WDOG_EN
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int falls;
      logic prev;
      falls = 0;
      n     = 0;
      prev  = pll_rst;
      while (fail !== 1'b1 && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
        if (prev === 1'b1 && pll_rst === 1'b0) falls++;
        prev = pll_rst;
      end
      check("wdog_fail_edge", n, 240);
      check("wdog_prst_pulses", falls, 3);
    end
    check("wdog_retries", retries, 3);
    check("wdog_pll_rst_held", pll_rst, 1);
    check("wdog_sys_rst_held", sys_rst, 1);
    pll_locked = 1'b1;
    tick(200);
    check("wdog_fail_sticky", fail, 1);
    check("wdog_pll_ok_low", pll_ok, 0);
    rst_n = 1'b0;
    #1;
    check("wdog_rst_fail", fail, 0);
    check("wdog_rst_retries", retries, 0);
    check("wdog_rst_pll_rst", pll_rst, 1);
    #10;
    rst_n = 1'b1;
`else
    tick(300);
    check("nowdog_fail_tied", fail, 0);
    check("nowdog_retries_tied", retries, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
